// File: rtl/cache_dm_param.sv
// rtl/cache_dm_param.sv - parametrised direct-mapped multiword-block instruction cache
// Registered one-cycle lookup; misses stall fetch via HitWrite while a block refill runs.
`timescale 1ns/1ps
module cache_dm_param #(
   parameter int WORDS_PER_BLOCK = 2,
   parameter int NUM_BLOCKS      = 4,
   parameter int CNT_W           = 20
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic [31:0]                  PC,
   input  logic                         Req,
   input  logic                         Flush,
   output logic                         Mem_Req,
   output logic [31:0]                  Mem_Addr,
   input  logic                         Mem_Ready,
   input  logic [32*WORDS_PER_BLOCK-1:0] Mem_Data,
   output logic                         HitWrite,
   output logic [31:0]                  Data_Cache,
   output logic [CNT_W-1:0]             CNT_HIT,
   output logic [CNT_W-1:0]             CNT_MISS,
   output logic [1:0]                   CONT
);

   localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam logic [31:0] BLK_MASK = (32'd1 << (OFF_W + 2)) - 32'd1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic {IDLE, WAIT} state_t;

   state_t state, state_n;

   logic [NUM_BLOCKS-1:0]            valid_q;
   logic [TAG_W-1:0]                 tag_mem [NUM_BLOCKS];
   logic [32*WORDS_PER_BLOCK-1:0]    blk_mem [NUM_BLOCKS];
   logic                             flush_pending, flush_pending_n;

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic [31:0]      block_addr;
   logic             line_valid;
   logic             hit;
   logic [31:0]      cached_word;
   logic [31:0]      refill_word;

   logic             hit_write_n, mem_req_n;
   logic [31:0]      data_n, addr_n;
   logic [CNT_W-1:0] cnt_hit_n, cnt_miss_n;
   logic [1:0]       cont_n;
   logic             clear_all, do_refill;

   assign pc_off      = PC[2 +: OFF_W];
   assign pc_idx      = PC[2 + OFF_W +: IDX_W];
   assign pc_tag      = PC[31 -: TAG_W];
   assign block_addr  = PC & ~BLK_MASK;
   assign line_valid  = valid_q[pc_idx];
   assign hit         = line_valid && (tag_mem[pc_idx] == pc_tag);
   assign cached_word = blk_mem[pc_idx][{pc_off, 5'b0} +: 32];
   assign refill_word = Mem_Data[{pc_off, 5'b0} +: 32];

   always_comb begin
      state_n         = state;
      hit_write_n     = HitWrite;
      data_n          = Data_Cache;
      mem_req_n       = Mem_Req;
      addr_n          = Mem_Addr;
      cnt_hit_n       = CNT_HIT;
      cnt_miss_n      = CNT_MISS;
      cont_n          = CONT;
      flush_pending_n = flush_pending;
      clear_all       = 1'b0;
      do_refill       = 1'b0;
      case (state)
         IDLE: begin
            if (Flush) begin
               clear_all   = 1'b1;
               hit_write_n = 1'b0;
               cont_n      = 2'd0;
            end else if (Req) begin
               if (hit) begin
                  data_n      = cached_word;
                  hit_write_n = 1'b1;
                  cont_n      = 2'd1;
                  if (CNT_HIT != CNT_MAX) cnt_hit_n = CNT_HIT + CNT_W'(1);
               end else begin
                  data_n      = 32'd0;
                  hit_write_n = 1'b0;
                  mem_req_n   = 1'b1;
                  addr_n      = block_addr;
                  cont_n      = line_valid ? 2'd3 : 2'd2;
                  state_n     = WAIT;
                  if (CNT_MISS != CNT_MAX) cnt_miss_n = CNT_MISS + CNT_W'(1);
               end
            end else begin
               hit_write_n = 1'b1;
            end
         end
         WAIT: begin
            hit_write_n = 1'b0;
            if (Flush) flush_pending_n = 1'b1;
            if (Mem_Ready) begin
               // A flush seen at any point during the refill leaves the whole cache empty.
               do_refill       = 1'b1;
               clear_all       = flush_pending || Flush;
               data_n          = refill_word;
               hit_write_n     = 1'b1;
               mem_req_n       = 1'b0;
               cont_n          = 2'd0;
               flush_pending_n = 1'b0;
               state_n         = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= IDLE;
         valid_q       <= '0;
         flush_pending <= 1'b0;
         HitWrite      <= 1'b1;
         Data_Cache    <= 32'd0;
         Mem_Req       <= 1'b0;
         Mem_Addr      <= 32'd0;
         CNT_HIT       <= '0;
         CNT_MISS      <= '0;
         CONT          <= 2'd0;
      end else begin
         state         <= state_n;
         flush_pending <= flush_pending_n;
         HitWrite      <= hit_write_n;
         Data_Cache    <= data_n;
         Mem_Req       <= mem_req_n;
         Mem_Addr      <= addr_n;
         CNT_HIT       <= cnt_hit_n;
         CNT_MISS      <= cnt_miss_n;
         CONT          <= cont_n;
         if (clear_all)
            valid_q <= '0;
         else if (do_refill)
            valid_q[pc_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET && do_refill) begin
         tag_mem[pc_idx] <= pc_tag;
         blk_mem[pc_idx] <= Mem_Data;
      end
   end

endmodule
